wordle_guess_ctrl: RTL and testbench
====================================

Name: wordle_guess_ctrl

Overview:
Entry-side controller for the Wordle game state machine. Turns Nexys4 pushbutton pulses into a five-letter guess buffer with letter cycling, commit and delete. On submit, it streams the letters one per handshake into the game FSM's letter input. It also tracks the number of submitted guesses and exposes the buffer for the display path.

Parameters:
WORD_LEN, 5, letters per guess; cursor/index width is 3 bits.
ALPHA_MIN, 8'h41, lowest selectable ASCII letter ('A').
ALPHA_MAX, 8'h5A, highest selectable ASCII letter ('Z').
MAX_GUESSES, 6, submits allowed before further submits are rejected.

Ports:
Clk  in  1  system clock.
reset  in  1  synchronous, active-high reset.
BtnU  in  1  one-cycle debounced pulse: next letter.
BtnD  in  1  one-cycle pulse: previous letter.
BtnR  in  1  one-cycle pulse: commit selected letter at cursor.
BtnL  in  1  one-cycle pulse: delete last committed letter.
BtnC  in  1  one-cycle pulse: submit guess.
abort  in  1  new-game clear, from game FSM QI/QDONE handling.
game_ready  in  1  game FSM is in a guess state and can accept a guess.
letter_ready  in  1  game FSM accepts letter_out this cycle.
letter_out  out  8  ASCII letter being streamed.
letter_valid  out  1  letter_out is valid.
guess_done  out  1  one-cycle pulse after the fifth letter transfers.
err  out  1  one-cycle pulse when a submit is rejected.
cursor  out  3  number of committed letters, 0..5.
sel_letter  out  8  currently selected letter.
buf_flat  out  40  {buf[0],...,buf[4]}; first letter in bits [39:32].
guess_count  out  3  accepted guesses, 0..MAX_GUESSES.
sending  out  1  high while in SEND.

Behaviour:
- Reset (sync, active-high, highest priority) sets:
  - state EDIT, cursor 0, every buf entry 8'h00, sel_letter 8'h41.
  - letter_out 8'h00, letter_valid 0, guess_done 0, err 0, guess_count 0, sending 0.
- All outputs are registered.
- States:
  - EDIT: accepts buttons.
  - SEND: streams letters.
- abort (next priority after reset), any state: next cycle is the reset condition, except sel_letter is kept. In SEND, letter_valid drops next cycle; no guess_done pulse, no count increment.
- EDIT: at most one action per cycle, priority C > L > R > U > D.
  - BtnU: sel = (sel==ALPHA_MAX) ? ALPHA_MIN : sel+1.
  - BtnD: sel = (sel==ALPHA_MIN) ? ALPHA_MAX : sel-1.
  - BtnR: if cursor<5, buf[cursor]<=sel and cursor++. If cursor==5 (full), ignored silently. sel unchanged.
  - BtnL: if cursor>0, buf[cursor-1]<=8'h00 and cursor--. If cursor==0 (empty), ignored.
  - BtnC, accepted when cursor==5 and game_ready and guess_count<MAX_GUESSES: go to SEND with index 0. Next cycle letter_valid=1, letter_out=buf[0], sending=1.
  - BtnC, otherwise: err=1 for exactly one cycle; state, buffer and count unchanged.
- SEND:
  - A transfer occurs on a cycle where letter_valid && letter_ready.
  - On each transfer, index++ and letter_out<=buf[index+1] the next cycle.
  - letter_valid stays high and letter_out stays stable until the transfer.
  - After the transfer of buf[4], next cycle:
    - letter_valid 0, guess_done 1 (one cycle), guess_count++ (saturating at MAX_GUESSES).
    - buffer cleared to 8'h00, cursor 0, state EDIT.
  - All buttons are ignored in SEND (no queuing).
  - game_ready is sampled only at submit; deassertion mid-SEND does not stall or abort the stream.
- Latency: BtnC at cycle N gives first letter_valid at N+1. With letter_ready held high, the 5 transfers occur at N+1..N+5 and guess_done at N+6.
- Back-to-back: a BtnC in the same cycle guess_done is high is processed as an EDIT action, so it raises err because cursor is 0.
- Internal index must never exceed 4. Any unreachable state encoding recovers to EDIT with buffer cleared.

Test Plan:
- Reset, then BtnU x2 → sel_letter 8'h43 ('C'); BtnD x3 from 'A' → 8'h58 ('X'), exercising wrap 'A'→'Z'.
- Commit R,O,B,O,T, then a sixth BtnR → cursor stays 5 and buf_flat=="ROBOT"; then BtnL → cursor 4, buf[4]=8'h00, buf_flat=="ROBO"+8'h00.
- "ROBOT" buffered, game_ready=1, letter_ready=1, BtnC at N → letter_valid at N+1..N+5 carrying 52,4F,42,4F,54; guess_done at N+6; guess_count 1; cursor 0.
- Same as above with letter_ready low on alternate cycles → each letter held stable until accepted; guess_done one cycle after 5th accept; buttons during SEND have no effect.
- BtnC with cursor 3, or game_ready=0, or guess_count 6 → err 1-cycle pulse, no letter_valid, buffer unchanged.
- abort asserted after the 2nd transfer → letter_valid 0 next cycle, no guess_done, guess_count 0, cursor 0, buf_flat 0.

Source files
------------

// File: rtl/wordle_guess_ctrl.sv
// rtl/wordle_guess_ctrl.sv - Wordle guess entry buffer and letter streamer
//
// Collects a five-letter guess from pushbutton pulses and streams it into the
// game FSM one letter per valid/ready handshake.
//
// Ports:
//   Clk, reset        clock and synchronous active-high reset
//   BtnU / BtnD       next / previous selectable letter (wraps A..Z)
//   BtnR / BtnL       commit selected letter at cursor / delete last letter
//   BtnC              submit the buffered guess
//   abort             new-game clear from the game FSM (selection is kept)
//   game_ready        game FSM can take a guess (sampled only at submit)
//   letter_ready      game FSM accepts letter_out this cycle
//   letter_out/valid  streamed letter and its valid flag
//   guess_done        one-cycle pulse after the last letter transfers
//   err               one-cycle pulse when a submit is rejected
//   cursor            number of committed letters
//   sel_letter        currently selected letter
//   buf_flat          buffer, first letter in the top byte
//   guess_count       accepted guesses, saturating at MAX_GUESSES
//   sending           high while the guess is being streamed
module wordle_guess_ctrl #(
  parameter int         WORD_LEN    = 5,
  parameter logic [7:0] ALPHA_MIN   = 8'h41,
  parameter logic [7:0] ALPHA_MAX   = 8'h5A,
  parameter int         MAX_GUESSES = 6
) (
  input  logic                  Clk,
  input  logic                  reset,
  input  logic                  BtnU,
  input  logic                  BtnD,
  input  logic                  BtnR,
  input  logic                  BtnL,
  input  logic                  BtnC,
  input  logic                  abort,
  input  logic                  game_ready,
  input  logic                  letter_ready,
  output logic [7:0]            letter_out,
  output logic                  letter_valid,
  output logic                  guess_done,
  output logic                  err,
  output logic [2:0]            cursor,
  output logic [7:0]            sel_letter,
  output logic [8*WORD_LEN-1:0] buf_flat,
  output logic [2:0]            guess_count,
  output logic                  sending
);

  localparam logic [2:0] FULL     = 3'(WORD_LEN);
  localparam logic [2:0] LAST_IDX = 3'(WORD_LEN - 1);
  localparam logic [2:0] MAX_G    = 3'(MAX_GUESSES);

  // Two-bit encoding leaves spare codes; those fall into the recovery branch.
  typedef enum logic [1:0] {
    EDIT = 2'd0,
    SEND = 2'd1
  } state_t;

  state_t     state;
  logic [2:0] idx;
  logic [7:0] letters [WORD_LEN];

  for (genvar i = 0; i < WORD_LEN; i++) begin : g_flat
    assign buf_flat[(WORD_LEN-1-i)*8 +: 8] = letters[i];
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      state        <= EDIT;
      idx          <= 3'd0;
      cursor       <= 3'd0;
      sel_letter   <= ALPHA_MIN;
      letter_out   <= 8'h00;
      letter_valid <= 1'b0;
      guess_done   <= 1'b0;
      err          <= 1'b0;
      guess_count  <= 3'd0;
      sending      <= 1'b0;
      for (int i = 0; i < WORD_LEN; i++) letters[i] <= 8'h00;
    end else if (abort) begin
      // Same as reset but the player's current letter selection survives.
      state        <= EDIT;
      idx          <= 3'd0;
      cursor       <= 3'd0;
      letter_out   <= 8'h00;
      letter_valid <= 1'b0;
      guess_done   <= 1'b0;
      err          <= 1'b0;
      guess_count  <= 3'd0;
      sending      <= 1'b0;
      for (int i = 0; i < WORD_LEN; i++) letters[i] <= 8'h00;
    end else begin
      guess_done <= 1'b0;
      err        <= 1'b0;
      case (state)
        EDIT: begin
          // One action per cycle: C > L > R > U > D.
          if (BtnC) begin
            if (cursor == FULL && game_ready && guess_count < MAX_G) begin
              state        <= SEND;
              idx          <= 3'd0;
              letter_out   <= letters[0];
              letter_valid <= 1'b1;
              sending      <= 1'b1;
            end else begin
              err <= 1'b1;
            end
          end else if (BtnL) begin
            if (cursor != 3'd0) begin
              letters[cursor - 3'd1] <= 8'h00;
              cursor                 <= cursor - 3'd1;
            end
          end else if (BtnR) begin
            if (cursor < FULL) begin
              letters[cursor] <= sel_letter;
              cursor          <= cursor + 3'd1;
            end
          end else if (BtnU) begin
            sel_letter <= (sel_letter == ALPHA_MAX) ? ALPHA_MIN : sel_letter + 8'd1;
          end else if (BtnD) begin
            sel_letter <= (sel_letter == ALPHA_MIN) ? ALPHA_MAX : sel_letter - 8'd1;
          end
        end

        SEND: begin
          // Buttons and game_ready are deliberately ignored while streaming.
          if (letter_valid && letter_ready) begin
            if (idx == LAST_IDX) begin
              state        <= EDIT;
              idx          <= 3'd0;
              cursor       <= 3'd0;
              letter_out   <= 8'h00;
              letter_valid <= 1'b0;
              sending      <= 1'b0;
              guess_done   <= 1'b1;
              if (guess_count < MAX_G) guess_count <= guess_count + 3'd1;
              for (int i = 0; i < WORD_LEN; i++) letters[i] <= 8'h00;
            end else begin
              idx        <= idx + 3'd1;
              letter_out <= letters[idx + 3'd1];
            end
          end
        end

        default: begin
          state        <= EDIT;
          idx          <= 3'd0;
          cursor       <= 3'd0;
          letter_out   <= 8'h00;
          letter_valid <= 1'b0;
          sending      <= 1'b0;
          for (int i = 0; i < WORD_LEN; i++) letters[i] <= 8'h00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wordle_guess_ctrl.sv
// tb/tb_wordle_guess_ctrl.sv - self-checking bench for wordle_guess_ctrl
module tb_wordle_guess_ctrl;

  logic        Clk = 1'b0;
  logic        reset, BtnU, BtnD, BtnR, BtnL, BtnC, abort, game_ready, letter_ready;
  logic [7:0]  letter_out, sel_letter;
  logic        letter_valid, guess_done, err, sending;
  logic [2:0]  cursor, guess_count;
  logic [39:0] buf_flat;

  wordle_guess_ctrl dut (
    .Clk(Clk), .reset(reset),
    .BtnU(BtnU), .BtnD(BtnD), .BtnR(BtnR), .BtnL(BtnL), .BtnC(BtnC),
    .abort(abort), .game_ready(game_ready), .letter_ready(letter_ready),
    .letter_out(letter_out), .letter_valid(letter_valid),
    .guess_done(guess_done), .err(err), .cursor(cursor),
    .sel_letter(sel_letter), .buf_flat(buf_flat),
    .guess_count(guess_count), .sending(sending)
  );

  always #5 Clk = ~Clk;

  int         applied = 0;
  int         miscompares = 0;
  logic [7:0] exp_q [$];

  localparam logic [39:0] ROBOT = 40'h52_4F_42_4F_54;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard side: every handshake pops the next expected letter; a letter
  // held without ready must not change on the following cycle.
  logic       held = 1'b0;
  logic [7:0] held_out = 8'h00;
  always @(negedge Clk) begin
    if (!reset) begin
      if (held && letter_valid) check("hold_stable", 64'(letter_out), 64'(held_out));
      if (letter_valid) check("sending_with_valid", 64'(sending), 64'd1);
      if (letter_valid && letter_ready && !abort) begin
        if (exp_q.size() == 0) begin
          applied++;
          miscompares++;
          $display("FAIL unexpected_xfer: got %h expected no transfer", letter_out);
        end else begin
          check("xfer_letter", 64'(letter_out), 64'(exp_q.pop_front()));
        end
      end
      held     = letter_valid && !letter_ready;
      held_out = letter_out;
    end
  end

  task automatic clr_btn();
    BtnU = 0; BtnD = 0; BtnR = 0; BtnL = 0; BtnC = 0;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic press(input logic u, input logic d, input logic r, input logic l, input logic c);
    {BtnU, BtnD, BtnR, BtnL, BtnC} = {u, d, r, l, c};
    tick();
    clr_btn();
  endtask

  task automatic goto_letter(input logic [7:0] t);
    for (int n = 0; n < 30 && sel_letter !== t; n++) press(1, 0, 0, 0, 0);
    check("goto_letter", 64'(sel_letter), 64'(t));
  endtask

  task automatic commit_word(input logic [39:0] w);
    for (int i = 0; i < 5; i++) begin
      goto_letter(w[39-8*i -: 8]);
      press(0, 0, 1, 0, 0);
    end
  endtask

  task automatic push_word(input logic [39:0] w);
    for (int i = 0; i < 5; i++) exp_q.push_back(w[39-8*i -: 8]);
  endtask

  typedef struct {
    logic        u, d, r, l, c;
    logic [7:0]  sel;
    logic [2:0]  cur;
    logic [39:0] bf;
    logic        er;
  } vec_t;

  vec_t vecs [20];

  initial begin
    int   cyc, nx;
    logic pending;
    logic [7:0] s0;

    reset = 1; abort = 0; game_ready = 0; letter_ready = 0;
    clr_btn();

    //           u d r l c  sel    cur   buf                  err
    vecs[0]  = '{1,0,0,0,0, 8'h42, 3'd0, 40'h0,               0};
    vecs[1]  = '{1,0,0,0,0, 8'h43, 3'd0, 40'h0,               0};
    vecs[2]  = '{0,1,0,0,0, 8'h42, 3'd0, 40'h0,               0};
    vecs[3]  = '{0,1,0,0,0, 8'h41, 3'd0, 40'h0,               0};
    vecs[4]  = '{0,1,0,0,0, 8'h5A, 3'd0, 40'h0,               0};
    vecs[5]  = '{0,1,0,0,0, 8'h59, 3'd0, 40'h0,               0};
    vecs[6]  = '{0,1,0,0,0, 8'h58, 3'd0, 40'h0,               0};
    vecs[7]  = '{1,0,0,0,0, 8'h59, 3'd0, 40'h0,               0};
    vecs[8]  = '{1,0,0,0,0, 8'h5A, 3'd0, 40'h0,               0};
    vecs[9]  = '{1,0,0,0,0, 8'h41, 3'd0, 40'h0,               0};
    vecs[10] = '{1,1,0,0,0, 8'h42, 3'd0, 40'h0,               0};
    vecs[11] = '{0,0,0,1,0, 8'h42, 3'd0, 40'h0,               0};
    vecs[12] = '{0,0,1,0,0, 8'h42, 3'd1, 40'h42_00_00_00_00,  0};
    vecs[13] = '{1,0,1,0,0, 8'h42, 3'd2, 40'h42_42_00_00_00,  0};
    vecs[14] = '{0,0,0,0,1, 8'h42, 3'd2, 40'h42_42_00_00_00,  1};
    vecs[15] = '{0,0,0,0,0, 8'h42, 3'd2, 40'h42_42_00_00_00,  0};
    vecs[16] = '{0,0,1,1,0, 8'h42, 3'd1, 40'h42_00_00_00_00,  0};
    vecs[17] = '{0,0,0,1,1, 8'h42, 3'd1, 40'h42_00_00_00_00,  1};
    vecs[18] = '{0,0,0,1,0, 8'h42, 3'd0, 40'h0,               0};
    vecs[19] = '{0,1,0,1,0, 8'h42, 3'd0, 40'h0,               0};

    repeat (3) tick();
    reset = 0;
    check("reset_sel", 64'(sel_letter), 64'h41);
    check("reset_cursor_buf", {21'd0, cursor, buf_flat}, 64'd0);
    check("reset_outs", {letter_out, letter_valid, guess_done, err, guess_count, sending},
          64'd0);

    // Editing table: game_ready low, so every submit must be rejected.
    for (int i = 0; i < 20; i++) begin
      {BtnU, BtnD, BtnR, BtnL, BtnC} = {vecs[i].u, vecs[i].d, vecs[i].r, vecs[i].l, vecs[i].c};
      tick();
      clr_btn();
      check($sformatf("vec%0d", i),
            {11'd0, sel_letter, cursor, buf_flat, err, letter_valid},
            {11'd0, vecs[i].sel, vecs[i].cur, vecs[i].bf, vecs[i].er, 1'b0});
    end

    // Fill, overflow, delete.
    commit_word(ROBOT);
    press(0, 0, 1, 0, 0);
    check("full_ignore", {cursor, buf_flat}, {3'd5, ROBOT});
    press(0, 0, 0, 1, 0);
    check("delete_last", {cursor, buf_flat}, {3'd4, 40'h52_4F_42_4F_00});
    press(0, 0, 1, 0, 0);
    check("recommit", {cursor, buf_flat}, {3'd5, ROBOT});

    // Full-rate stream with exact latency, then back-to-back submit.
    game_ready = 1; letter_ready = 1;
    push_word(ROBOT);
    press(0, 0, 0, 0, 1);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("stream_valid%0d", k), {letter_valid, guess_done}, 2'b10);
      tick();
    end
    check("done_pulse", {letter_valid, guess_done, sending}, 3'b010);
    check("after_guess1", {guess_count, cursor, buf_flat}, {3'd1, 3'd0, 40'h0});
    press(0, 0, 0, 0, 1);
    check("b2b_err", {err, guess_done, letter_valid}, 3'b100);
    tick();
    check("err_one_cycle", 64'(err), 64'd0);
    check("q_empty1", 64'(exp_q.size()), 64'd0);

    // Throttled stream with buttons hammered during SEND.
    commit_word(ROBOT);
    s0 = sel_letter;
    letter_ready = 0;
    push_word(ROBOT);
    press(0, 0, 0, 0, 1);
    nx = 0;
    cyc = 0;
    while (cyc < 40) begin
      letter_ready = cyc[0];
      {BtnU, BtnD, BtnR, BtnL, BtnC} = {1'b1, 1'b0, 1'b1, cyc[1], cyc[2]};
      pending = letter_valid && letter_ready;
      tick();
      cyc++;
      if (pending) nx++;
      if (pending && nx == 5) begin
        check("slow_done", 64'(guess_done), 64'd1);
        break;
      end
      check("slow_no_done_err", {guess_done, err}, 2'b00);
    end
    clr_btn();
    if (cyc >= 40) begin
      applied++;
      miscompares++;
      $display("FAIL slow_timeout: got %0d transfers expected 5", nx);
    end
    check("slow_after", {sel_letter, guess_count, cursor, buf_flat}, {s0, 3'd2, 3'd0, 40'h0});
    check("q_empty2", 64'(exp_q.size()), 64'd0);

    // Abort after the second transfer.
    commit_word(ROBOT);
    s0 = sel_letter;
    letter_ready = 1;
    push_word(ROBOT);
    press(0, 0, 0, 0, 1);
    tick();
    tick();
    check("abort_pre", {letter_valid, letter_out}, {1'b1, 8'h42});
    abort = 1; letter_ready = 0;
    tick();
    abort = 0;
    check("abort_state", {letter_valid, guess_done, sending, guess_count, cursor, buf_flat},
          {3'b000, 3'd0, 3'd0, 40'h0});
    check("abort_sel_kept", 64'(sel_letter), 64'(s0));
    check("abort_q_left", 64'(exp_q.size()), 64'd3);
    exp_q.delete();
    tick();
    check("abort_no_late_done", {guess_done, letter_valid}, 2'b00);

    // Rejections: partial buffer, and game not ready.
    letter_ready = 1;
    repeat (3) press(0, 0, 1, 0, 0);
    press(0, 0, 0, 0, 1);
    check("rej_cursor3", {err, letter_valid, cursor, buf_flat},
          {2'b10, 3'd3, s0, s0, s0, 16'h0});
    game_ready = 0;
    repeat (2) press(0, 0, 1, 0, 0);
    press(0, 0, 0, 0, 1);
    check("rej_not_ready", {err, letter_valid, cursor, buf_flat},
          {2'b10, 3'd5, s0, s0, s0, s0, s0});
    tick();
    check("rej_no_stream", {err, letter_valid}, 2'b00);

    // Six accepted guesses (buffer already full for the first), then reject.
    game_ready = 1;
    for (int g = 0; g < 6; g++) begin
      if (g != 0) repeat (5) press(0, 0, 1, 0, 0);
      push_word({s0, s0, s0, s0, s0});
      press(0, 0, 0, 0, 1);
      cyc = 0;
      while (guess_done !== 1'b1 && cyc < 20) begin
        tick();
        cyc++;
      end
      check($sformatf("guess%0d_done", g + 1), {guess_done, guess_count}, {1'b1, 3'(g + 1)});
    end
    repeat (5) press(0, 0, 1, 0, 0);
    press(0, 0, 0, 0, 1);
    check("rej_max", {err, letter_valid, guess_count, buf_flat},
          {2'b10, 3'd6, s0, s0, s0, s0, s0});
    tick();
    check("rej_max_idle", {letter_valid, sending, err}, 3'b000);
    check("q_empty3", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
